dct_block_sched: RTL and testbench
==================================

Name: dct_block_sched

Overview:
Central sequencer for the 2-D DCT datapath. It takes the loader's block-full pulse and issues eight row-DCT starts. It manages ownership of the two transpose-buffer banks (ping-pong) and issues eight column-DCT starts per filled bank. Column work is gated on output-packer block credits, so one block can be in row processing while the previous one is in column processing.

Parameters:
ROWS, 8, rows/columns per block (log2 width ROW_W = $clog2(ROWS))
OUT_CREDITS, 2, blocks the output packer can absorb before it must report completion
CREDIT_W, $clog2(OUT_CREDITS+1), credit counter width

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
block_ready  in  1  1-cycle pulse from loader: 8x8 pixel block complete
loader_hold  out  1  high: loader must not complete another block (block pending, not yet taken)
buf_release  out  1  1-cycle pulse: pixel block buffer fully consumed by row DCT
row_start  out  1  1-cycle start pulse to row DCT engine
row_sel  out  ROW_W  row index for current row_start, 0..7
row_done  in  1  1-cycle pulse: row DCT result written
tp_wr_bank  out  1  transpose bank currently written by row side
col_start  out  1  1-cycle start pulse to column DCT engine
col_sel  out  ROW_W  column index for current col_start
col_done  in  1  1-cycle pulse: column DCT result delivered to quantizer
tp_rd_bank  out  1  transpose bank currently read by column side
out_block_done  in  1  1-cycle pulse: packer emitted m_tlast handshake (returns one credit)
busy  out  1  any block pending, in row, or in column processing
err_overflow  out  1  sticky: block_ready while a block already pending
err_spurious  out  1  sticky: row_done/col_done outside the matching WAIT state

Behaviour:
- Reset values: all outputs 0; tp_wr_bank = tp_rd_bank = 0; bank_full[1:0] = 0; pending = 0; credits = OUT_CREDITS; both FSMs in IDLE. Reset mid-block discards all work and clears both sticky errors.
- pending sets on block_ready and clears when the row FSM leaves R_IDLE. loader_hold = pending.
- block_ready with pending = 1 sets err_overflow. The extra pulse is dropped and pending stays 1.
- Row FSM (R_IDLE, R_ISSUE, R_WAIT):
  - R_IDLE -> R_ISSUE when pending and !bank_full[tp_wr_bank]; row counter loads 0.
  - R_ISSUE: row_start = 1 and row_sel = counter for exactly one cycle; go to R_WAIT.
  - R_WAIT on row_done with counter < 7: increment counter, go to R_ISSUE.
  - R_WAIT on row_done with counter = 7: set bank_full[tp_wr_bank], toggle tp_wr_bank, pulse buf_release, go to R_IDLE.
  - tp_wr_bank changes only at that final transition.
  - Latency: block_ready at cycle t gives row_start at t+2 when a bank is free. row_done at t gives the next row_start at t+1.
- Column FSM (C_IDLE, C_ISSUE, C_WAIT):
  - C_IDLE -> C_ISSUE when bank_full[tp_rd_bank] and credits > 0; credits decrements on this transition.
  - C_ISSUE and C_WAIT behave like the row side but drive col_start/col_sel and advance on col_done.
  - After col 7 completes: clear bank_full[tp_rd_bank], toggle tp_rd_bank, go to C_IDLE.
- Credits: increment on out_block_done and decrement on column-block start. Both in the same cycle leaves credits unchanged. out_block_done with credits = OUT_CREDITS saturates and sets err_spurious.
- bank_full set (row side) and clear (column side) in the same cycle always address different banks, and both apply. A bank cleared at cycle t is seen as free by the row FSM at t+1 (registered, no combinational bypass).
- Both banks full: the row FSM stalls in R_IDLE, pending stays 1, and loader_hold stays 1.
- row_done in a state other than R_WAIT, or col_done in a state other than C_WAIT, is ignored and sets err_spurious.
- busy = pending | (row FSM != R_IDLE) | (column FSM != C_IDLE) | bank_full[0] | bank_full[1].

Decomposition:
- Package dct_pkg holds:
  - row_state_t and col_state_t enums;
  - DCT_N = 8 and its log2;
  - shared bank index type tp_bank_t.
- One sub-module, dct_seq8: generic ISSUE/WAIT 8-step sequencer with go, step_done, start, sel and last_done. It is instantiated once for rows and once for columns. Bank and credit bookkeeping stays in dct_block_sched.

Test Plan:
- Single block (engines respond with done 3 cycles after start): block_ready at t -> row_start at t+2 with row_sel 0..7 in order, then buf_release; tp_wr_bank 0->1; col_start 0..7 on bank 0; tp_rd_bank -> 1; busy falls after the last col_done.
- Two back-to-back blocks: block 2's row_start is issued while block 1's columns are running, and block 2's rows write bank 1 while bank 0 is read.
- Credit starvation (OUT_CREDITS = 2, out_block_done withheld): a third filled bank waits in C_IDLE with no col_start; a single out_block_done -> col_start 2 cycles later.
- Both banks full plus a pending block: loader_hold stays 1 and no row_start. After a column block completes -> row_start one cycle after bank_full clears.
- Error paths: double block_ready -> err_overflow = 1 and only one block processed; row_done in R_IDLE -> err_spurious = 1 with no state change.
- Reset asserted mid R_WAIT (row 4): all outputs return to reset values asynchronously, and the next block starts at row_sel 0 on bank 0.

Source files
------------

// File: rtl/dct_pkg.sv
// dct_pkg: shared block geometry, transpose-bank index and sequencer state types
// for the 2-D DCT scheduler.
package dct_pkg;
    localparam int DCT_N = 8;
    localparam int DCT_W = $clog2(DCT_N);
    typedef logic tp_bank_t;
    typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_WAIT} row_state_t;
    typedef enum logic [1:0] {C_IDLE, C_ISSUE, C_WAIT} col_state_t;
endpackage

// File: rtl/dct_block_sched_if.sv
// dct_block_sched_if: loader, row/column engine and output-packer handshakes
// seen by the block scheduler.
interface dct_block_sched_if #(
    parameter int ROW_W = 3
);
    logic             block_ready;
    logic             loader_hold;
    logic             buf_release;
    logic             row_start;
    logic [ROW_W-1:0] row_sel;
    logic             row_done;
    logic             tp_wr_bank;
    logic             col_start;
    logic [ROW_W-1:0] col_sel;
    logic             col_done;
    logic             tp_rd_bank;
    logic             out_block_done;
    logic             busy;
    logic             err_overflow;
    logic             err_spurious;

    modport master (
        input  block_ready, row_done, col_done, out_block_done,
        output loader_hold, buf_release, row_start, row_sel, tp_wr_bank,
               col_start, col_sel, tp_rd_bank, busy, err_overflow, err_spurious
    );
    modport slave (
        output block_ready, row_done, col_done, out_block_done,
        input  loader_hold, buf_release, row_start, row_sel, tp_wr_bank,
               col_start, col_sel, tp_rd_bank, busy, err_overflow, err_spurious
    );
endinterface

// File: rtl/dct_seq8.sv
// dct_seq8: issue/wait sequencer stepping an engine through N starts, one per step_done.
// Row and column state enums share this encoding, so state is exported raw.
module dct_seq8
    import dct_pkg::*;
#(
    parameter int N = DCT_N,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         go,
    input  logic         step_done,
    output logic         start,
    output logic [W-1:0] sel,
    output logic         last_done,
    output logic         spurious,
    output logic [1:0]   state
);
    row_state_t   st, st_nx;
    logic [W-1:0] cnt, cnt_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st  <= R_IDLE;
            cnt <= '0;
        end else begin
            st  <= st_nx;
            cnt <= cnt_nx;
        end
    end

    always_comb begin
        st_nx     = st;
        cnt_nx    = cnt;
        last_done = st == R_WAIT && step_done && cnt == W'(N - 1);
        case (st)
            R_IDLE:  if (go) begin st_nx = R_ISSUE; cnt_nx = '0; end
            R_ISSUE: st_nx = R_WAIT;
            R_WAIT:  if (step_done) begin st_nx = last_done ? R_IDLE : R_ISSUE; cnt_nx = cnt + 1'b1; end
            default: st_nx = R_IDLE;
        endcase
    end

    assign start    = st == R_ISSUE;
    assign sel      = cnt;
    assign spurious = step_done && st != R_WAIT;
    assign state    = st;
endmodule

// File: rtl/dct_block_sched.sv
// dct_block_sched: 2-D DCT block sequencer; the row pass fills one ping-pong transpose
// bank while the column pass drains the other under output-packer credit control.
module dct_block_sched
    import dct_pkg::*;
#(
    parameter int ROWS        = DCT_N,
    parameter int OUT_CREDITS = 2,
    parameter int CREDIT_W    = $clog2(OUT_CREDITS + 1)
) (
    input logic               clk,
    input logic               rst_n,
    dct_block_sched_if.master bus
);
    logic [1:0]          row_q, col_q;
    row_state_t          row_st;
    col_state_t          col_st;
    tp_bank_t            wr_bank, rd_bank;
    logic [1:0]          bank_full, bank_set, bank_clr;
    logic [CREDIT_W-1:0] credits;
    logic                pending, row_go, col_go, row_last, col_last, row_spur, col_spur;
    logic                credit_ovf, buf_release, err_overflow, err_spurious;

    assign row_st     = row_state_t'(row_q);
    assign col_st     = col_state_t'(col_q);
    assign row_go     = row_st == R_IDLE && pending && !bank_full[wr_bank];
    assign col_go     = col_st == C_IDLE && bank_full[rd_bank] && credits != '0;
    // a credit returned in the same cycle a column block starts is simply consumed
    assign credit_ovf = bus.out_block_done && !col_go && credits == CREDIT_W'(OUT_CREDITS);
    assign bank_set   = row_last ? 2'b01 << wr_bank : 2'b00;
    assign bank_clr   = col_last ? 2'b01 << rd_bank : 2'b00;

    dct_seq8 #(.N(ROWS)) u_row (
        .clk, .rst_n, .go(row_go), .step_done(bus.row_done), .start(bus.row_start),
        .sel(bus.row_sel), .last_done(row_last), .spurious(row_spur), .state(row_q)
    );

    dct_seq8 #(.N(ROWS)) u_col (
        .clk, .rst_n, .go(col_go), .step_done(bus.col_done), .start(bus.col_start),
        .sel(bus.col_sel), .last_done(col_last), .spurious(col_spur), .state(col_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending      <= 1'b0;
            wr_bank      <= 1'b0;
            rd_bank      <= 1'b0;
            bank_full    <= '0;
            buf_release  <= 1'b0;
            credits      <= CREDIT_W'(OUT_CREDITS);
            err_overflow <= 1'b0;
            err_spurious <= 1'b0;
        end else begin
            pending      <= row_go ? 1'b0 : pending | bus.block_ready;
            wr_bank      <= wr_bank ^ row_last;
            rd_bank      <= rd_bank ^ col_last;
            bank_full    <= (bank_full | bank_set) & ~bank_clr;
            buf_release  <= row_last;
            if (col_go && !bus.out_block_done)
                credits <= credits - CREDIT_W'(1);
            else if (bus.out_block_done && !col_go && !credit_ovf)
                credits <= credits + CREDIT_W'(1);
            err_overflow <= err_overflow | (bus.block_ready & pending);
            err_spurious <= err_spurious | row_spur | col_spur | credit_ovf;
        end
    end

    assign bus.loader_hold  = pending;
    assign bus.buf_release  = buf_release;
    assign bus.tp_wr_bank   = wr_bank;
    assign bus.tp_rd_bank   = rd_bank;
    assign bus.busy         = pending | row_st != R_IDLE | col_st != C_IDLE | |bank_full;
    assign bus.err_overflow = err_overflow;
    assign bus.err_spurious = err_spurious;
endmodule

// File: tb/tb_dct_block_sched.sv
// tb_dct_block_sched: directed checks of the DCT block scheduler with engines that
// answer 3 cycles after each start and a packer whose credits are returned by hand.
module tb_dct_block_sched;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   row_cnt = 0, col_cnt = 0, overlap = 0;

    dct_block_sched_if #(.ROW_W(3)) bus ();

    dct_block_sched #(.ROWS(8), .OUT_CREDITS(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.row_start) row_cnt++;
        if (bus.col_start) col_cnt++;
        if (bus.row_start && bus.col_start && bus.tp_wr_bank != bus.tp_rd_bank) overlap++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_block();
        bus.block_ready = 1'b1;
        step();
        bus.block_ready = 1'b0;
    endtask

    task automatic pulse_credit();
        bus.out_block_done = 1'b1;
        step();
        bus.out_block_done = 1'b0;
    endtask

    task automatic run_rows(input logic bank, input int nrows, output int first_wait);
        first_wait = 0;
        for (int i = 0; i < nrows; i++) begin
            int n;
            n = 0;
            while (bus.row_start !== 1'b1 && n < 100) begin step(); n++; end
            if (i == 0) first_wait = n;
            chk("row_start", bus.row_start, 1);
            chk("row_sel", bus.row_sel, i);
            chk("row_wr_bank", bus.tp_wr_bank, bank);
            repeat (3) step();
            bus.row_done = 1'b1;
            step();
            bus.row_done = 1'b0;
        end
        if (nrows == 8) begin
            chk("buf_release", bus.buf_release, 1);
            chk("wr_bank_toggle", bus.tp_wr_bank, !bank);
        end
    endtask

    task automatic run_cols(input logic bank, output int first_wait);
        first_wait = 0;
        for (int i = 0; i < 8; i++) begin
            int n;
            n = 0;
            while (bus.col_start !== 1'b1 && n < 100) begin step(); n++; end
            if (i == 0) first_wait = n;
            chk("col_start", bus.col_start, 1);
            chk("col_sel", bus.col_sel, i);
            chk("col_rd_bank", bus.tp_rd_bank, bank);
            repeat (3) step();
            bus.col_done = 1'b1;
            step();
            bus.col_done = 1'b0;
        end
        chk("rd_bank_toggle", bus.tp_rd_bank, !bank);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int fw, fw2, fw3, fw4, base_r, base_c, base_o;
        bus.block_ready = 1'b0;
        bus.row_done = 1'b0;
        bus.col_done = 1'b0;
        bus.out_block_done = 1'b0;
        repeat (3) step();
        chk("rst_busy", bus.busy, 0);
        chk("rst_hold", bus.loader_hold, 0);
        chk("rst_row_start", bus.row_start, 0);
        chk("rst_col_start", bus.col_start, 0);
        chk("rst_wr_bank", bus.tp_wr_bank, 0);
        chk("rst_rd_bank", bus.tp_rd_bank, 0);
        chk("rst_errs", {bus.err_overflow, bus.err_spurious}, 0);
        rst_n = 1'b1;
        step();

        // single block: rows into bank 0, then columns out of bank 0
        pulse_block();
        chk("t1_hold", bus.loader_hold, 1);
        chk("t1_busy", bus.busy, 1);
        chk("t1_no_start_t1", bus.row_start, 0);
        step();
        chk("t1_start_t2", bus.row_start, 1);
        chk("t1_hold_cleared", bus.loader_hold, 0);
        run_rows(0, 8, fw);
        chk("t1_row_first_wait", fw, 0);
        chk("t1_busy_mid", bus.busy, 1);
        run_cols(0, fw);
        chk("t1_col_first_wait", fw, 1);
        chk("t1_busy_end", bus.busy, 0);
        pulse_credit();

        // back-to-back blocks: block 2 rows on bank 0 overlap block 1 columns on bank 1
        base_o = overlap;
        pulse_block();
        fork
            begin run_rows(1, 8, fw); run_rows(0, 8, fw2); end
            begin run_cols(1, fw3); run_cols(0, fw4); end
            begin repeat (6) step(); pulse_block(); end
        join
        chk("t2_row2_first_wait", fw2, 1);
        chk("t2_overlap", overlap - base_o, 8);
        chk("t2_no_overflow", bus.err_overflow, 0);
        chk("t2_busy_end", bus.busy, 0);

        // credit starvation: filled bank 1 waits with no column start
        base_c = col_cnt;
        pulse_block();
        run_rows(1, 8, fw);
        repeat (10) step();
        chk("t3_no_col_start", col_cnt - base_c, 0);
        chk("t3_busy", bus.busy, 1);

        // both banks full plus a pending block
        pulse_block();
        run_rows(0, 8, fw);
        base_r = row_cnt;
        pulse_block();
        repeat (10) step();
        chk("t4_hold", bus.loader_hold, 1);
        chk("t4_no_row_start", row_cnt - base_r, 0);
        chk("t4_no_col_start", col_cnt - base_c, 0);
        pulse_credit();
        chk("t4_col_start_t1", bus.col_start, 0);
        step();
        chk("t4_col_start_t2", bus.col_start, 1);
        run_cols(1, fw);
        chk("t4_row_start_wait", bus.row_start, 0);
        chk("t4_hold_wait", bus.loader_hold, 1);
        step();
        chk("t4_row_start_free", bus.row_start, 1);
        run_rows(1, 8, fw);
        pulse_credit();
        run_cols(0, fw);
        pulse_credit();
        run_cols(1, fw);
        chk("t4_busy_end", bus.busy, 0);
        pulse_credit();
        pulse_credit();
        chk("t4_no_spurious", bus.err_spurious, 0);

        // double block_ready: flagged and only one block processed
        bus.block_ready = 1'b1;
        step();
        step();
        bus.block_ready = 1'b0;
        chk("t5_overflow", bus.err_overflow, 1);
        chk("t5_row_start", bus.row_start, 1);
        run_rows(0, 8, fw);
        run_cols(0, fw);
        base_r = row_cnt;
        repeat (10) step();
        chk("t5_one_block", row_cnt - base_r, 0);
        chk("t5_hold", bus.loader_hold, 0);
        chk("t5_busy", bus.busy, 0);

        // row_done while idle
        bus.row_done = 1'b1;
        step();
        bus.row_done = 1'b0;
        chk("t5_spurious", bus.err_spurious, 1);
        chk("t5_spur_busy", bus.busy, 0);
        chk("t5_spur_row_start", bus.row_start, 0);
        chk("t5_spur_wr_bank", bus.tp_wr_bank, 1);

        // asynchronous reset while waiting on row 4
        pulse_block();
        run_rows(1, 4, fw);
        chk("t6_row4_sel", bus.row_sel, 4);
        step();
        #3 rst_n = 1'b0;
        #1;
        chk("t6_rst_busy", bus.busy, 0);
        chk("t6_rst_wr_bank", bus.tp_wr_bank, 0);
        chk("t6_rst_rd_bank", bus.tp_rd_bank, 0);
        chk("t6_rst_spurious", bus.err_spurious, 0);
        chk("t6_rst_overflow", bus.err_overflow, 0);
        chk("t6_rst_row_start", bus.row_start, 0);
        #2 rst_n = 1'b1;
        step();
        pulse_block();
        run_rows(0, 8, fw);
        chk("t6_row_first_wait", fw, 1);
        run_cols(0, fw);
        pulse_credit();
        chk("t6_credit_full_ok", bus.err_spurious, 0);
        pulse_credit();
        chk("t6_credit_saturate", bus.err_spurious, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
